// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake
// and holds each instruction until the decode/execute path consumes it.
module instr_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] PCTarget,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             instr_valid,
  output logic             fetch_error,
  output logic [31:0]      instr_count
);

  // state | meaning
  // IDLE  | after reset, no request   ; FETCH | request outstanding at PC
  // VALID | instruction held for decode, waiting for Stall=0
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_req;
  logic             r_valid;
  logic             r_err;
  logic [31:0]      r_count;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_target;
  logic             w_misaligned;

  assign w_pc_plus4   = r_pc + WIDTH'(4);
  assign w_target     = {PCTarget[WIDTH-1:2], 2'b00};
  assign w_misaligned = |PCTarget[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end
        end
        S_VALID: begin
          if (!Stall) begin
            r_pc    <= PCSrc ? w_target : w_pc_plus4;
            r_count <= r_count + 32'd1;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
            // misaligned target is aligned down but remembered
            if (PCSrc && w_misaligned) r_err <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign Instr       = r_instr;
  assign instr_valid = r_valid;
  assign fetch_error = r_err;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver plays memory and consumer,
// a transaction-level PC model feeds queues popped by a negedge monitor.
module tb_instr_fetch_unit;

  logic        clk, rst, Stall, PCSrc, imem_ready;
  logic [31:0] PCTarget, imem_rdata;
  logic        imem_req, instr_valid, fetch_error;
  logic [31:0] imem_addr, Instr, PC, PCPlus4, instr_count;
  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_count;

  instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .fetch_error(fetch_error), .instr_count(instr_count));

  instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(w_req),
    .imem_addr(w_addr), .Instr(w_instr), .PC(w_pc), .PCPlus4(w_pc4),
    .instr_valid(w_valid), .fetch_error(w_err), .instr_count(w_count));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        err;
    int          n_wait;
    int          n_stall;
  } rec_t;

  logic [31:0] exp_addr[$];
  rec_t        exp_rec[$];
  int          n_pass = 0;
  int          n_total = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Monitor
  int   cyc = 0, req_cyc = 0, valid_len = 0;
  bit   prev_req = 0, prev_valid = 0;
  rec_t cur;
  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      prev_req = 0;
      prev_valid = 0;
    end else begin
      chk("req_valid_exclusive", {31'b0, imem_req & instr_valid}, 32'd0);
      if (imem_req && !prev_req) begin
        req_cyc = cyc;
        chk("addr_q_nonempty", {31'b0, exp_addr.size() != 0}, 32'd1);
        if (exp_addr.size() != 0) begin
          logic [31:0] a;
          a = exp_addr.pop_front();
          chk("fetch_addr", imem_addr, a);
          chk("fetch_pc", PC, a);
        end
      end
      if (instr_valid && !prev_valid) begin
        chk("rec_q_nonempty", {31'b0, exp_rec.size() != 0}, 32'd1);
        if (exp_rec.size() != 0) begin
          cur = exp_rec.pop_front();
          chk("instr", Instr, cur.instr);
          chk("pc", PC, cur.pc);
          chk("pcplus4", PCPlus4, cur.pc + 32'd4);
          chk("instr_count", instr_count, cur.cnt);
          chk("fetch_error", {31'b0, fetch_error}, {31'b0, cur.err});
          chk("req_to_valid", 32'(cyc - req_cyc), 32'(cur.n_wait + 1));
        end
        valid_len = 0;
      end
      if (instr_valid) begin
        valid_len++;
        chk("hold_instr", Instr, cur.instr);
        chk("hold_pc", PC, cur.pc);
        chk("hold_count", instr_count, cur.cnt);
      end
      if (!instr_valid && prev_valid)
        chk("valid_len", 32'(valid_len), 32'(cur.n_stall + 1));
      prev_req = imem_req;
      prev_valid = instr_valid;
    end
  end

  // Directed head of the stimulus, random tail
  localparam int N_DIR = 7;
  localparam int N_ITER = 45;
  int          d_wait [N_DIR] = '{0, 0, 3, 0, 1, 0, 2};
  int          d_stall[N_DIR] = '{0, 0, 5, 0, 2, 0, 0};
  bit          d_src  [N_DIR] = '{0, 0, 0, 1, 1, 1, 0};
  logic [31:0] d_tgt  [N_DIR] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h206, 32'hFFFF_FFFF, 32'h0};

  logic [31:0] pc_m, cnt_m;
  bit          err_m;

  initial begin
    int          nw, ns;
    bit          src;
    logic [31:0] tgt, data;
    rst = 1; Stall = 0; PCSrc = 0; PCTarget = 0; imem_ready = 0; imem_rdata = 0;
    pc_m = 32'h0; cnt_m = 0; err_m = 0;
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h13);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_err", {31'b0, fetch_error}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_pcplus4", PCPlus4, 32'd4);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_pcplus4", w_pc4, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr.push_back(pc_m);
    mon_en = 1;
    rst = 0;
    imem_ready = 1; imem_rdata = 32'hBAD0_BAD0;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < N_ITER; i++) begin
      if (i < N_DIR) begin
        nw = d_wait[i]; ns = d_stall[i]; src = d_src[i]; tgt = d_tgt[i];
        data = (i == 0) ? 32'h33 : $urandom;
      end else begin
        nw = $urandom_range(0, 4); ns = $urandom_range(0, 3);
        src = ($urandom_range(0, 2) == 0); tgt = $urandom; data = $urandom;
      end
      if (i == 1) begin
        chk("wrap_addr", w_addr, 32'h0);
        chk("wrap_err", {31'b0, w_err}, 32'd0);
      end
      for (int k = 0; k < nw; k++) begin
        imem_ready = 0; imem_rdata = $urandom;
        Stall = $urandom; PCSrc = $urandom; PCTarget = $urandom;
        @(posedge clk); #1;
      end
      imem_ready = 1; imem_rdata = data;
      Stall = $urandom; PCSrc = $urandom; PCTarget = $urandom;
      exp_rec.push_back('{data, pc_m, cnt_m, err_m, nw, ns});
      @(posedge clk); #1;
      for (int k = 0; k < ns; k++) begin
        Stall = 1; imem_ready = $urandom; imem_rdata = $urandom;
        PCSrc = $urandom; PCTarget = $urandom;
        @(posedge clk); #1;
      end
      Stall = 0; PCSrc = src; PCTarget = tgt;
      imem_ready = $urandom; imem_rdata = $urandom;
      pc_m  = src ? (tgt & ~32'd3) : pc_m + 32'd4;
      if (src && (tgt % 4 != 0)) err_m = 1;
      cnt_m = cnt_m + 1;
      exp_addr.push_back(pc_m);
      @(posedge clk); #1;
    end

    imem_ready = 0; Stall = 0; PCSrc = 0;
    @(negedge clk); #1;
    mon_en = 0;
    chk("addr_q_drained", exp_addr.size(), 32'd0);
    chk("rec_q_drained", exp_rec.size(), 32'd0);
    chk("final_count", instr_count, cnt_m);
    chk("final_err", {31'b0, fetch_error}, {31'b0, err_m});
    chk("final_req", {31'b0, imem_req}, 32'd1);
    #1;
    rst = 1;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_instr", Instr, 32'h13);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_count", instr_count, 32'd0);
    chk("midrst_err", {31'b0, fetch_error}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_ready = 0;
    chk("stale_ready_instr", Instr, 32'h13);
    chk("stale_ready_valid", {31'b0, instr_valid}, 32'd0);
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
